// File: rtl/fib_pkg.sv
// Shared definitions for the Fibonacci generator / inverse-Fibonacci pair:
// one-hot controller state encodings and the default index width.
package fib_pkg;

    localparam int FIB_IW_DEFAULT = 7;

    typedef enum logic [2:0] {
        IDLE   = 3'b001,
        SEARCH = 3'b010,
        DONE   = 3'b100
    } fib_state_t;

endpackage : fib_pkg

// File: rtl/fib_index.sv
// Inverse Fibonacci unit: returns the largest k with fib(k) <= value and an exact-match flag.
// Optional remainder output (value - fib(k)) enabled by defining FIB_INDEX_REM_EN.
module fib_index
    import fib_pkg::*;
#(
    parameter int N  = 16,
    parameter int IW = FIB_IW_DEFAULT
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [N-1:0]  value,
    output logic          ready,
    output logic          done,
    output logic [IW-1:0] idx,
    output logic          is_fib
`ifdef FIB_INDEX_REM_EN
    ,
    output logic [N-1:0]  rem
`endif
);

    fib_state_t    state_reg, state_next;
    logic [N-1:0]  v_reg;
    logic [N:0]    t0_reg, t1_reg;
    logic [IW-1:0] k_reg;
    logic [IW-1:0] idx_reg;
    logic          is_fib_reg;
    logic          accept;
    logic          search_end;

    assign accept     = (state_reg == IDLE) && start;
    // t1 is one bit wider than v, so the compare is done against zero-extended v.
    assign search_end = (state_reg == SEARCH) && (t1_reg > {1'b0, v_reg});

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        ready      = 1'b0;
        done       = 1'b0;
        case (state_reg)
            IDLE: begin
                ready = 1'b1;
                if (start) begin
                    state_next = SEARCH;
                end
            end
            SEARCH: begin
                if (search_end) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                done       = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            v_reg      <= '0;
            t0_reg     <= '0;
            t1_reg     <= '0;
            k_reg      <= '0;
            idx_reg    <= '0;
            is_fib_reg <= 1'b0;
        end else if (accept) begin
            v_reg  <= value;
            t0_reg <= '0;
            t1_reg <= (N+1)'(1);
            k_reg  <= '0;
        end else if (state_reg == SEARCH) begin
            if (search_end) begin
                idx_reg    <= k_reg;
                is_fib_reg <= (t0_reg == {1'b0, v_reg});
            end else begin
                // Invariant t0=fib(k), t1=fib(k+1) with t1 <= v, so the sum fits N+1 bits.
                t0_reg <= t1_reg;
                t1_reg <= t0_reg + t1_reg;
                k_reg  <= k_reg + IW'(1);
            end
        end
    end

    assign idx    = idx_reg;
    assign is_fib = is_fib_reg;

`ifdef FIB_INDEX_REM_EN
    logic [N-1:0] rem_reg;

    always_ff @(posedge clk) begin
        if (!rst) begin
            rem_reg <= '0;
        end else if (search_end) begin
            rem_reg <= v_reg - t0_reg[N-1:0];
        end
    end

    assign rem = rem_reg;
`endif

    // A wrapped N+1-bit sum would show up as the sequence going backwards.
    a_no_overflow : assert property (@(posedge clk) disable iff (!rst)
        (state_reg == SEARCH) |-> (t1_reg >= t0_reg));

endmodule : fib_index

// File: tb/tb_fib_index.sv
// Directed bench for fib_index: table-based reference model checked every cycle,
// plus literal per-operation expectations.
module tb_fib_index;

    localparam int N  = 16;
    localparam int IW = 7;

    logic          clk;
    logic          rst;
    logic          start;
    logic [N-1:0]  value;
    logic          ready;
    logic          done;
    logic [IW-1:0] idx;
    logic          is_fib;
`ifdef FIB_INDEX_REM_EN
    logic [N-1:0]  rem;
`endif

    fib_index #(.N(N), .IW(IW)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .value  (value),
        .ready  (ready),
        .done   (done),
        .idx    (idx),
        .is_fib (is_fib)
`ifdef FIB_INDEX_REM_EN
        ,
        .rem    (rem)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec  = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: explicit Fibonacci table, answer found by searching it downward.
    longint fib_tab [0:40];
    initial begin
        fib_tab[0] = 0;
        fib_tab[1] = 1;
        for (int i = 2; i <= 40; i++) fib_tab[i] = fib_tab[i-1] + fib_tab[i-2];
    end

    function automatic int ref_idx(input longint v);
        for (int k = 40; k >= 0; k--) begin
            if (fib_tab[k] <= v) return k;
        end
        return 0;
    endfunction

    // Model timeline: cycles remaining before ready returns; done is the last busy cycle.
    int     m_busy;
    int     m_idx, p_idx;
    logic   m_fib, p_fib;
    longint m_rem, p_rem;
    logic   cmp_en = 1'b0;

    always @(posedge clk) begin
        if (!rst) begin
            m_busy <= 0;
            m_idx  <= 0;
            m_fib  <= 1'b0;
            m_rem  <= 0;
        end else if (m_busy == 0) begin
            if (start) begin
                p_idx  <= ref_idx(longint'(value));
                p_fib  <= (fib_tab[ref_idx(longint'(value))] == longint'(value));
                p_rem  <= longint'(value) - fib_tab[ref_idx(longint'(value))];
                m_busy <= ref_idx(longint'(value)) + 2;
            end
        end else begin
            m_busy <= m_busy - 1;
            if (m_busy == 2) begin
                m_idx <= p_idx;
                m_fib <= p_fib;
                m_rem <= p_rem;
            end
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            check("ready", 64'(ready), 64'(m_busy == 0));
            check("done", 64'(done), 64'(m_busy == 1));
            check("idx", 64'(idx), 64'(m_idx));
            check("is_fib", 64'(is_fib), 64'(m_fib));
`ifdef FIB_INDEX_REM_EN
            check("rem", 64'(rem), 64'(m_rem));
`endif
        end
    end

    // Called right after a negedge with the DUT in IDLE; returns one cycle after done.
    task automatic run_op(input logic [N-1:0] val, input int e_idx, input int e_fib,
                          input int e_rem, input int e_lat, input bit pulse);
        int cnt;
        start = 1'b1;
        value = val;
        @(negedge clk);
        cnt = 1;
        while (!done && cnt < 200) begin
            if (pulse && cnt == 3) begin
                start = 1'b1;
                value = 16'd5;
            end else begin
                start = 1'b0;
                value = N'($urandom);
            end
            @(negedge clk);
            cnt++;
        end
        start = 1'b0;
        $display("op value=%0d: latency=%0d idx=%0d is_fib=%0d", val, cnt, idx, is_fib);
        check("latency", 64'(cnt), 64'(e_lat));
        check("lit_idx", 64'(idx), 64'(e_idx));
        check("lit_is_fib", 64'(is_fib), 64'(e_fib));
`ifdef FIB_INDEX_REM_EN
        check("lit_rem", 64'(rem), 64'(e_rem));
`else
        if (e_rem < 0) check("lit_rem_arg", 64'(e_rem), 64'(0));
`endif
        @(negedge clk);
    endtask

    initial begin
        int cnt;
        int seen;
        rst   = 1'b0;
        start = 1'b0;
        value = '0;
        @(posedge clk);
        #1 cmp_en = 1'b1;
        @(negedge clk);
        rst = 1'b1;
        check("rst_ready", 64'(ready), 64'(1));
        check("rst_done", 64'(done), 64'(0));
        check("rst_idx", 64'(idx), 64'(0));
        check("rst_is_fib", 64'(is_fib), 64'(0));
        @(negedge clk);

        run_op(16'd0,     0,  1, 0,     2,  1'b0);
        run_op(16'd21,    8,  1, 0,     10, 1'b0);
        run_op(16'd20,    7,  0, 7,     9,  1'b0);
        run_op(16'd1,     2,  1, 0,     4,  1'b0);
        run_op(16'd65535, 24, 0, 19167, 26, 1'b0);
        run_op(16'd100,   11, 0, 11,    13, 1'b1);

        // Back-to-back: start held high across DONE.
        start = 1'b1;
        value = 16'd3;
        @(negedge clk);
        cnt = 1;
        while (!done && cnt < 200) begin
            @(negedge clk);
            cnt++;
        end
        check("b2b_lat1", 64'(cnt), 64'(6));
        check("b2b_idx1", 64'(idx), 64'(4));
        check("b2b_fib1", 64'(is_fib), 64'(1));
        value = 16'd4;
        @(negedge clk);
        cnt = 1;
        while (!done && cnt < 200) begin
            @(negedge clk);
            cnt++;
        end
        start = 1'b0;
        $display("b2b second op value=4: latency=%0d idx=%0d is_fib=%0d", cnt, idx, is_fib);
        check("b2b_lat2", 64'(cnt), 64'(7));
        check("b2b_idx2", 64'(idx), 64'(4));
        check("b2b_fib2", 64'(is_fib), 64'(0));
        @(negedge clk);

        // Reset in the middle of a long search.
        start = 1'b1;
        value = 16'd65535;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        $display("mid-search reset: ready=%0d done=%0d idx=%0d", ready, done, idx);
        check("mrst_ready", 64'(ready), 64'(1));
        check("mrst_done", 64'(done), 64'(0));
        check("mrst_idx", 64'(idx), 64'(0));
        seen = 0;
        repeat (30) begin
            @(negedge clk);
            if (done) seen++;
        end
        check("mrst_no_done", 64'(seen), 64'(0));
        run_op(16'd2, 3, 1, 0, 5, 1'b0);

        repeat (2) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule : tb_fib_index
